// File: rtl/multdiv_stage_pkg.sv
// ============================================================================
// Module      : multdiv_stage_pkg
// Description : Shared decode constants, state encoding and default width for
//               the execute-stage multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_stage_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [4:0] OPCODE_RTYPE = 5'b00000;
    localparam logic [4:0] ALUOP_MUL    = 5'b00110;
    localparam logic [4:0] ALUOP_DIV    = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdState_t;

endpackage

`default_nettype wire

// File: rtl/md_iter_datapath.sv
// ============================================================================
// Module      : md_iter_datapath
// Description : Iterative shift-add multiply / restoring divide on unsigned
//               magnitudes, one bit per step, with its iteration counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_iter_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               isDiv,
    input  logic [WIDTH-1:0]   loadA,
    input  logic [WIDTH-1:0]   loadB,
    output logic [2*WIDTH-1:0] accNext,
    output logic               lastIter
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opB;
    logic [CNT_W-1:0]   r_count;

    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_shift;
    logic               w_geq;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_divNext;

    assign w_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo = r_acc[WIDTH-1:0];

    // Multiply: high half accumulates, low half holds the not-yet-consumed multiplier bits.
    assign w_addend  = w_lo[0] ? r_opB : '0;
    assign w_sum     = {1'b0, w_hi} + {1'b0, w_addend};
    assign w_mulNext = {w_sum, w_lo[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign w_shift   = {w_hi, w_lo[WIDTH-1]};
    assign w_geq     = w_shift >= {1'b0, r_opB};
    assign w_rem     = w_shift[WIDTH-1:0] - r_opB;
    assign w_divNext = {(w_geq ? w_rem : w_shift[WIDTH-1:0]), w_lo[WIDTH-2:0], w_geq};

    assign accNext  = isDiv ? w_divNext : w_mulNext;
    assign lastIter = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_opB   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_acc   <= {{WIDTH{1'b0}}, loadA};
            r_opB   <= loadB;
            r_count <= '0;
        end else if (step) begin
            r_acc   <= accNext;
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/multdiv_stage.sv
// ============================================================================
// Module      : multdiv_stage
// Description : Execute-stage multi-cycle signed multiply/divide: decode,
//               stall control, sign/overflow fix-up and writeback registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_stage
    import multdiv_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      dx_insn,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [31:0]      pw_insn
);

    mdState_t r_state;
    mdState_t w_nextState;

    logic               w_isRtype;
    logic               w_isMulOp;
    logic               w_isDivOp;
    logic               w_start;
    logic               w_divByZero;
    logic               w_stepping;
    logic               w_finish;
    logic               w_lastIter;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [2*WIDTH-1:0] w_accNext;
    logic [2*WIDTH-1:0] w_prodSigned;
    logic               w_mulOvf;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_quotSigned;
    logic               w_divOvf;

    logic               r_isDiv;
    logic               r_neg;
    logic [31:0]        r_insn;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;
    logic [31:0]        r_pwInsn;

    assign w_isRtype   = (dx_insn[31:27] == OPCODE_RTYPE);
    assign w_isMulOp   = w_isRtype && (dx_insn[6:2] == ALUOP_MUL);
    assign w_isDivOp   = w_isRtype && (dx_insn[6:2] == ALUOP_DIV);
    assign w_start     = (r_state == ST_IDLE) && (w_isMulOp || w_isDivOp);
    assign w_divByZero = w_isDivOp && (op_b == '0);
    assign w_stepping  = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_finish    = w_stepping && w_lastIter;

    // Most negative operand negates to itself, which reads correctly as an unsigned magnitude.
    assign w_magA = op_a[WIDTH-1] ? (-op_a) : op_a;
    assign w_magB = op_b[WIDTH-1] ? (-op_b) : op_b;

    md_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clock),
        .rst_n    (reset),
        .load     (w_start),
        .step     (w_stepping),
        .isDiv    (r_isDiv),
        .loadA    (w_magA),
        .loadB    (w_magB),
        .accNext  (w_accNext),
        .lastIter (w_lastIter)
    );

    assign w_prodSigned = r_neg ? (-w_accNext) : w_accNext;
    assign w_mulOvf     = (w_prodSigned[2*WIDTH-1:WIDTH] != {WIDTH{w_prodSigned[WIDTH-1]}});
    assign w_quot       = w_accNext[WIDTH-1:0];
    assign w_quotSigned = r_neg ? (-w_quot) : w_quot;
    assign w_divOvf     = !r_neg && w_quot[WIDTH-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_isDivOp) begin
                        w_nextState = w_divByZero ? ST_DONE : ST_DIV;
                    end else begin
                        w_nextState = ST_MUL;
                    end
                end
            end
            ST_MUL:  if (w_lastIter) w_nextState = ST_DONE;
            ST_DIV:  if (w_lastIter) w_nextState = ST_DONE;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_isDiv     <= 1'b0;
            r_neg       <= 1'b0;
            r_insn      <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_pwInsn    <= '0;
        end else begin
            if (w_start) begin
                r_isDiv <= w_isDivOp;
                r_neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                r_insn  <= dx_insn;
                if (w_divByZero) begin
                    r_result    <= '0;
                    r_exception <= 1'b1;
                    r_pwInsn    <= dx_insn;
                end
            end
            if (w_finish) begin
                r_result    <= r_isDiv ? w_quotSigned : w_prodSigned[WIDTH-1:0];
                r_exception <= r_isDiv ? w_divOvf : w_mulOvf;
                r_pwInsn    <= r_insn;
            end
        end
    end

    // Stall is forced low while reset is held, even though IDLE would otherwise see a start.
    assign stall      = reset && (w_start || w_stepping);
    assign result_rdy = (r_state == ST_DONE);
    assign result     = r_result;
    assign exception  = r_exception;
    assign pw_insn    = r_pwInsn;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_stage.sv
// ============================================================================
// Module      : tb_multdiv_stage
// Description : Directed, table-driven self-checking bench for multdiv_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_stage;

    logic        clock;
    logic        reset;
    logic [31:0] dx_insn;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        result_rdy;
    logic [31:0] result;
    logic        exception;
    logic [31:0] pw_insn;

    int checks;
    int failures;

    multdiv_stage #(
        .WIDTH (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dx_insn    (dx_insn),
        .op_a       (op_a),
        .op_b       (op_b),
        .stall      (stall),
        .result_rdy (result_rdy),
        .result     (result),
        .exception  (exception),
        .pw_insn    (pw_insn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    function automatic logic [31:0] mkInsn(input logic [4:0] opcode, input logic [4:0] aluop,
                                           input logic [4:0] rd);
        return {opcode, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, follow it to result_rdy, then advance D/X to nextInsn.
    task automatic runOp(input string name, input vec_t v, input logic [31:0] nextInsn);
        int lat;
        int stallCnt;
        @(posedge clock); #1;
        dx_insn = v.insn;
        op_a    = v.a;
        op_b    = v.b;
        #1;
        lat      = 0;
        stallCnt = 0;
        while (!result_rdy && lat < 40) begin
            if (stall) stallCnt++;
            @(posedge clock); #2;
            lat++;
        end
        check({name, "_rdy_seen"}, 32'(result_rdy), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(v.lat));
        check({name, "_stall_cycles"}, 32'(stallCnt), 32'(v.lat));
        check({name, "_stall_in_done"}, 32'(stall), 32'd0);
        check({name, "_result"}, result, v.res);
        check({name, "_exception"}, 32'(exception), 32'(v.exc));
        check({name, "_pw_insn"}, pw_insn, v.insn);
        @(posedge clock); #1;
        dx_insn = nextInsn;
        op_a    = 32'h1234_5678;
        op_b    = 32'h0000_0003;
        #1;
        check({name, "_rdy_pulse_end"}, 32'(result_rdy), 32'd0);
        check({name, "_no_restart_stall"}, 32'(stall), 32'd0);
        check({name, "_result_hold"}, result, v.res);
    endtask

    vec_t vecs[10];
    logic [31:0] mulI, divI, addI, nopI, fakeMulI;

    initial begin
        checks   = 0;
        failures = 0;
        mulI     = mkInsn(5'b00000, 5'b00110, 5'd5);
        divI     = mkInsn(5'b00000, 5'b00111, 5'd9);
        addI     = mkInsn(5'b00000, 5'b00000, 5'd3);
        nopI     = 32'h0000_0000;
        fakeMulI = mkInsn(5'b00101, 5'b00110, 5'd7);

        vecs[0] = '{mulI, 32'd7,          32'hFFFF_FFFA, 33, 32'hFFFF_FFD6, 1'b0};
        vecs[1] = '{mulI, 32'h0001_0000,  32'h0001_0000, 33, 32'h0000_0000, 1'b1};
        vecs[2] = '{divI, 32'd100,        32'd7,         33, 32'h0000_000E, 1'b0};
        vecs[3] = '{divI, 32'hFFFF_FF9C,  32'd7,         33, 32'hFFFF_FFF2, 1'b0};
        vecs[4] = '{divI, 32'd5,          32'd0,          1, 32'h0000_0000, 1'b1};
        vecs[5] = '{divI, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1};
        vecs[6] = '{mulI, 32'h8000_0000,  32'd1,         33, 32'h8000_0000, 1'b0};
        vecs[7] = '{mulI, 32'hFFFF_FFFD,  32'hFFFF_FFFB, 33, 32'h0000_000F, 1'b0};
        vecs[8] = '{divI, 32'd7,          32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{mulI, 32'h7FFF_FFFF,  32'd2,         33, 32'hFFFF_FFFE, 1'b1};

        // Reset held with a mul in D/X: everything must read zero, no stall.
        reset   = 1'b0;
        dx_insn = mulI;
        op_a    = 32'd3;
        op_b    = 32'd4;
        repeat (2) @(posedge clock);
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdy", 32'(result_rdy), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_exception", 32'(exception), 32'd0);
        check("rst_pw_insn", pw_insn, 32'd0);
        dx_insn = nopI;
        @(posedge clock); #1;
        reset = 1'b1;

        // Non-R-type instruction whose low field looks like mul must not start.
        @(posedge clock); #1;
        dx_insn = fakeMulI;
        #1;
        check("fake_mul_stall", 32'(stall), 32'd0);
        @(posedge clock); #2;
        check("fake_mul_stall_next", 32'(stall), 32'd0);
        check("fake_mul_no_rdy", 32'(result_rdy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            runOp($sformatf("v%0d", i), vecs[i], (i % 2 == 0) ? addI : nopI);
        end

        // Abort a mul mid-iteration with a one-cycle reset pulse.
        begin
            int rdySeen;
            @(posedge clock); #1;
            dx_insn = mulI;
            op_a    = 32'd3;
            op_b    = 32'd4;
            #1;
            check("abort_stall_start", 32'(stall), 32'd1);
            repeat (10) @(posedge clock);
            #1;
            reset   = 1'b0;
            dx_insn = nopI;
            #1;
            check("abort_stall", 32'(stall), 32'd0);
            check("abort_rdy", 32'(result_rdy), 32'd0);
            check("abort_result", result, 32'd0);
            check("abort_exception", 32'(exception), 32'd0);
            check("abort_pw_insn", pw_insn, 32'd0);
            @(posedge clock); #1;
            reset   = 1'b1;
            rdySeen = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clock); #2;
                if (result_rdy || stall) rdySeen++;
            end
            check("abort_no_rdy_after", 32'(rdySeen), 32'd0);
        end

        runOp("post_abort", '{mulI, 32'd3, 32'd4, 33, 32'd12, 1'b0}, addI);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
